// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants: mnemonic set, primary opcodes and R-type funct codes.
package mips_pkg;

  localparam int unsigned OPC_W   = 6;
  localparam int unsigned FUNCT_W = 6;
  localparam int unsigned WORD_W  = 32;

  typedef enum logic [4:0] {
    NEM_ZERO  = 5'd0,
    NEM_ADD   = 5'd1,
    NEM_SUB   = 5'd2,
    NEM_AND   = 5'd3,
    NEM_OR    = 5'd4,
    NEM_XOR   = 5'd5,
    NEM_SLT   = 5'd6,
    NEM_SLL   = 5'd7,
    NEM_SRL   = 5'd8,
    NEM_SRA   = 5'd9,
    NEM_ADDI  = 5'd10,
    NEM_ADDIU = 5'd11,
    NEM_BEQ   = 5'd12,
    NEM_LW    = 5'd13,
    NEM_SW    = 5'd14,
    NEM_JUMP  = 5'd15,
    NEM_ABS   = 5'd16
  } t_instr_pnmen;

  localparam logic [OPC_W-1:0] OPC_ZERO  = 6'h00;
  localparam logic [OPC_W-1:0] OPC_JUMP  = 6'h02;
  localparam logic [OPC_W-1:0] OPC_BEQ   = 6'h04;
  localparam logic [OPC_W-1:0] OPC_ADDI  = 6'h08;
  localparam logic [OPC_W-1:0] OPC_ADDIU = 6'h09;
  localparam logic [OPC_W-1:0] OPC_ABS   = 6'h1C;
  localparam logic [OPC_W-1:0] OPC_LW    = 6'h23;
  localparam logic [OPC_W-1:0] OPC_SW    = 6'h2B;

  localparam logic [FUNCT_W-1:0] FN_SLL = 6'h00;
  localparam logic [FUNCT_W-1:0] FN_SRL = 6'h02;
  localparam logic [FUNCT_W-1:0] FN_SRA = 6'h03;
  localparam logic [FUNCT_W-1:0] FN_ADD = 6'h20;
  localparam logic [FUNCT_W-1:0] FN_SUB = 6'h22;
  localparam logic [FUNCT_W-1:0] FN_AND = 6'h24;
  localparam logic [FUNCT_W-1:0] FN_OR  = 6'h25;
  localparam logic [FUNCT_W-1:0] FN_XOR = 6'h26;
  localparam logic [FUNCT_W-1:0] FN_SLT = 6'h2A;

endpackage

// File: rtl/instr_encode_loader.sv
// Encodes one mnemonic bundle per handshake into a MIPS word and streams the
// words into instruction memory from a programmable base byte address.
module instr_encode_loader
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  count,
  input  logic              in_valid,
  output logic              in_ready,
  input  t_instr_pnmen      in_pnem,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err_unsupported,
  output logic              nop_alias
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} state_e;
  typedef enum logic [2:0] {FMT_ZERO, FMT_R, FMT_I, FMT_J, FMT_ABS, FMT_BAD} fmt_e;

  state_e              state, state_d;
  fmt_e                fmt;
  logic [OPC_W-1:0]    opcode;
  logic [FUNCT_W-1:0]  funct;
  logic [WORD_W-1:0]   enc_word;
  logic                enc_bad;
  logic                enc_alias;
  logic                xfer;

  logic [ADDR_W-1:0]   wr_addr, wr_addr_d;
  logic [CNT_W-1:0]    remaining, remaining_d;
  logic                err_d, we_d, alias_d, ready_d, busy_d, done_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [WORD_W-1:0]   wdata_d;

  // Mnemonic classification into an encoding format plus opcode/funct.
  always_comb begin
    fmt    = FMT_ZERO;
    opcode = OPC_ZERO;
    funct  = FN_SLL;
    case (in_pnem)
      NEM_ZERO:  fmt = FMT_ZERO;
      NEM_ADD:   begin fmt = FMT_R; funct = FN_ADD; end
      NEM_SUB:   begin fmt = FMT_R; funct = FN_SUB; end
      NEM_AND:   begin fmt = FMT_R; funct = FN_AND; end
      NEM_OR:    begin fmt = FMT_R; funct = FN_OR;  end
      NEM_XOR:   begin fmt = FMT_R; funct = FN_XOR; end
      NEM_SLT:   begin fmt = FMT_R; funct = FN_SLT; end
      NEM_SLL:   begin fmt = FMT_R; funct = FN_SLL; end
      NEM_SRL:   begin fmt = FMT_R; funct = FN_SRL; end
      NEM_SRA:   begin fmt = FMT_R; funct = FN_SRA; end
      NEM_ADDI:  begin fmt = FMT_I; opcode = OPC_ADDI;  end
      NEM_ADDIU: begin fmt = FMT_I; opcode = OPC_ADDIU; end
      NEM_BEQ:   begin fmt = FMT_I; opcode = OPC_BEQ;   end
      NEM_LW:    begin fmt = FMT_I; opcode = OPC_LW;    end
      NEM_SW:    begin fmt = FMT_I; opcode = OPC_SW;    end
      NEM_JUMP:  fmt = FMT_J;
      NEM_ABS:   fmt = FMT_ABS;
      default:   fmt = FMT_BAD;
    endcase
  end

  // Field packing; every slot is exactly as wide as its input.
  always_comb begin
    enc_word = '0;
    case (fmt)
      FMT_R:   enc_word = {OPC_ZERO, in_rs, in_rt, in_rd, in_shamt, funct};
      FMT_I:   enc_word = {opcode, in_rs, in_rt, in_imm};
      FMT_J:   enc_word = {OPC_JUMP, in_target};
      FMT_ABS: enc_word = {OPC_ABS, in_rs, in_rt, in_rd, 11'b0};
      default: enc_word = '0;
    endcase
  end

  assign enc_bad   = (fmt == FMT_BAD);
  assign enc_alias = (in_pnem != NEM_ZERO) && !enc_bad && (enc_word == '0);

  // Session control and next values of every registered output.
  always_comb begin
    state_d     = state;
    wr_addr_d   = wr_addr;
    remaining_d = remaining;
    err_d       = err_unsupported;
    we_d        = 1'b0;
    addr_d      = mem_addr;
    wdata_d     = mem_wdata;
    alias_d     = 1'b0;
    xfer        = in_valid && in_ready;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_RUN;
          wr_addr_d   = base_addr;
          remaining_d = count;
          err_d       = 1'b0;
        end
      end
      ST_RUN: begin
        if (xfer) begin
          we_d        = 1'b1;
          addr_d      = wr_addr;
          wdata_d     = enc_word;
          alias_d     = enc_alias;
          wr_addr_d   = wr_addr + ADDR_W'(4);
          remaining_d = remaining - CNT_W'(1);
          if (enc_bad) err_d = 1'b1;
        end
        // The final write leaves this cycle, so DONE follows it by one cycle.
        if (remaining == '0) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_RUN) && (remaining_d != '0);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      wr_addr         <= '0;
      remaining       <= '0;
      err_unsupported <= 1'b0;
      mem_we          <= 1'b0;
      mem_addr        <= '0;
      mem_wdata       <= '0;
      nop_alias       <= 1'b0;
      in_ready        <= 1'b0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      state           <= state_d;
      wr_addr         <= wr_addr_d;
      remaining       <= remaining_d;
      err_unsupported <= err_d;
      mem_we          <= we_d;
      mem_addr        <= addr_d;
      mem_wdata       <= wdata_d;
      nop_alias       <= alias_d;
      in_ready        <= ready_d;
      busy            <= busy_d;
      done            <= done_d;
    end
  end

endmodule
